reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (RDaddr/RDdata/RegWrite) between two
//  writeback requesters: A = ALU result path, B = load/multi-cycle unit path.
//  Round-robin arbitration, valid/ready handshake, one registered output stage that
//  drives the register file write port directly. Sits between the execute units and
//  the register file.
// PARAMETERS
//  DATA_W  32  width of write data
//  ADDR_W  5   width of register address (32 registers)
// PORTS
//  clk_i       in   1       clock; all state updates on rising edge
//  rst_i       in   1       synchronous reset, active-low
//  a_valid_i   in   1       requester A has a write pending
//  a_addr_i    in   ADDR_W  requester A destination register
//  a_data_i    in   DATA_W  requester A write data
//  a_ready_o   out  1       A's request accepted this cycle (comb.)
//  b_valid_i   in   1       requester B has a write pending
//  b_addr_i    in   ADDR_W  requester B destination register
//  b_data_i    in   DATA_W  requester B write data
//  b_ready_o   out  1       B's request accepted this cycle (comb.)
//  wr_hold_i   in   1       stall: freeze the output stage (RF write port unavailable)
//  RDaddr_o    out  ADDR_W  register-file write address (registered)
//  RDdata_o    out  DATA_W  register-file write data (registered)
//  RegWrite_o  out  1       register-file write enable (registered)
//  grant_o     out  2       {B,A} one-hot: source of the current output-stage entry
// BEHAVIOUR
//  - Reset (rst_i==0 at clk edge): RDaddr_o=0, RDdata_o=0, RegWrite_o=0, grant_o=2'b00,
//    out_valid=0, last_grant=B (so A wins the first contention). Reset has priority over
//    everything, incl. mid-transfer; an entry held in the stage is discarded.
//  - Stage-free: can_accept = !out_valid || !wr_hold_i.
//  - Arbitration (comb.): only A valid -> A; only B -> B; both -> the one != last_grant.
//    a_ready_o/b_ready_o = can_accept && selected; at most one high per cycle.
//    Neither valid -> both ready low.
//  - Transfer on valid&&ready: next edge loads RDaddr_o/RDdata_o from winner,
//    out_valid=1, grant_o=winner, last_grant=winner. Latency: accept -> RF write = 1 clk.
//  - RegWrite_o = out_valid && !wr_hold_i && (RDaddr_o != 0). Writes to r0 are accepted
//    and consumed (handshake completes) but never asserted to the RF.
//  - wr_hold_i=1 with out_valid: stage and outputs hold; RegWrite_o=0; ready low.
//  - Accept with no new winner and stage drained: out_valid=0, grant_o=2'b00; addr/data
//    hold last value.
//  - Back-to-back: with wr_hold_i=0 one write per cycle; sustained dual requests
//    alternate A,B,A,B; no requester waits more than 1 grant.
//  - Requesters must hold valid/addr/data stable until ready; the arbiter does not
//    latch unaccepted requests.
// CONFIGURATION
//  WB_FWD_EN defined: adds inputs RSaddr_i, RTaddr_i (ADDR_W) and outputs RSfwd_o,
//    RTfwd_o (1). RSfwd_o = out_valid && RDaddr_o!=0 && RDaddr_o==RSaddr_i (same for RT),
//    comb. Lets the decode stage bypass RDdata_o while a write is pending/held.
//  WB_FWD_EN undefined: those ports and logic do not exist; behaviour otherwise identical.
// TESTING
//  1 reset: rst_i=0 one edge mid-transfer -> all outputs 0, grant_o=00, next A/B
//    contention grants A.
//  2 single: A valid addr=5 data=32'h1234 -> a_ready_o=1 same cycle; next cycle
//    RDaddr_o=5, RDdata_o=32'h1234, RegWrite_o=1, grant_o=01.
//  3 contention: A(addr 3,d=7) and B(addr 9,d=99) held valid 4 cycles -> grants A,B,A,B;
//    RF writes r3,r9,r3,r9 on consecutive cycles.
//  4 hold: stage holds r8=5, wr_hold_i=1 3 cycles with B valid -> RegWrite_o=0,
//    b_ready_o=0, outputs stable; hold released -> r8 written, B accepted same cycle.
//  5 zero reg: B writes addr 0 data 32'hFFFF -> b_ready_o=1, next cycle RegWrite_o=0,
//    grant_o=10.
//  6 (WB_FWD_EN) stage holds r12, RSaddr_i=12, RTaddr_i=0 -> RSfwd_o=1, RTfwd_o=0;
//    RDaddr_o=0 with RSaddr_i=0 -> RSfwd_o=0.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter sharing the register-file write port
// between the ALU writeback path (A) and the load/multi-cycle path (B).
// One registered output stage drives RDaddr_o/RDdata_o; RegWrite_o is gated
// by the stall input and suppressed for r0.
// Optional feature macro: WB_FWD_EN adds RS/RT bypass-match outputs that
// compare decode source registers against the entry held in the stage.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  input  logic              wr_hold_i,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic              RSfwd_o,
  output logic              RTfwd_o,
`endif
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic              RegWrite_o,
  output logic [1:0]        grant_o
);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_b_q, last_b_d;   // 1: B won the most recent transfer

  logic can_accept;
  logic sel_a;
  logic sel_b;

  // Round-robin winner selection and ready generation
  always_comb begin
    can_accept = !out_valid_q || !wr_hold_i;
    sel_a      = a_valid_i && (!b_valid_i || last_b_q);
    sel_b      = b_valid_i && !sel_a;
    a_ready_o  = can_accept && sel_a;
    b_ready_o  = can_accept && sel_b;
  end

  // Output-stage next state: load the winner, drain when idle, freeze on stall
  always_comb begin
    out_valid_d = out_valid_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    grant_d     = grant_q;
    last_b_d    = last_b_q;
    if (can_accept) begin
      if (sel_a) begin
        out_valid_d = 1'b1;
        rd_addr_d   = a_addr_i;
        rd_data_d   = a_data_i;
        grant_d     = 2'b01;
        last_b_d    = 1'b0;
      end else if (sel_b) begin
        out_valid_d = 1'b1;
        rd_addr_d   = b_addr_i;
        rd_data_d   = b_data_i;
        grant_d     = 2'b10;
        last_b_d    = 1'b1;
      end else begin
        // Stage drained: address/data keep their last value
        out_valid_d = 1'b0;
        grant_d     = 2'b00;
      end
    end
  end

  // Stage registers; reset discards any held entry and favours A next
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      grant_q     <= 2'b00;
      last_b_q    <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      grant_q     <= grant_d;
      last_b_q    <= last_b_d;
    end
  end

  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign grant_o    = grant_q;
  assign RegWrite_o = out_valid_q && !wr_hold_i && (rd_addr_q != '0);

`ifdef WB_FWD_EN
  assign RSfwd_o = out_valid_q && (rd_addr_q != '0) && (rd_addr_q == RSaddr_i);
  assign RTfwd_o = out_valid_q && (rd_addr_q != '0) && (rd_addr_q == RTaddr_i);
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: directed vector table followed by
// constrained-random traffic checked against a behavioural model.
module tb_reg_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              a_valid_i, b_valid_i, wr_hold_i;
  logic [ADDR_W-1:0] a_addr_i, b_addr_i;
  logic [DATA_W-1:0] a_data_i, b_data_i;
  logic              a_ready_o, b_ready_o, RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [1:0]        grant_o;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] RSaddr_i, RTaddr_i;
  logic              RSfwd_o, RTfwd_o;
`endif

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .wr_hold_i(wr_hold_i),
`ifdef WB_FWD_EN
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSfwd_o(RSfwd_o), .RTfwd_o(RTfwd_o),
`endif
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o), .grant_o(grant_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the write-port stage seen as one optional entry,
  // plus the identity of the requester that was served last.
  logic              m_full;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_src;
  logic              m_last_b;

  function automatic logic win_a();
    // A wins alone, or in contention when B was served last
    return a_valid_i && (!b_valid_i || m_last_b);
  endfunction

  function automatic logic win_b();
    return b_valid_i && !(a_valid_i && (!b_valid_i || m_last_b));
  endfunction

  function automatic logic stage_free();
    return !m_full || !wr_hold_i;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_addr = '0; m_data = '0; m_src = 2'b00; m_last_b = 1'b1;
  endtask

  task automatic model_clock();
    logic wa, wb;
    wa = win_a();
    wb = win_b();
    if (!rst_i) model_reset();
    else if (stage_free()) begin
      if (wa)      begin m_full = 1'b1; m_addr = a_addr_i; m_data = a_data_i; m_src = 2'b01; m_last_b = 1'b0; end
      else if (wb) begin m_full = 1'b1; m_addr = b_addr_i; m_data = b_data_i; m_src = 2'b10; m_last_b = 1'b1; end
      else         begin m_full = 1'b0; m_src = 2'b00; end
    end
  endtask

  typedef struct {
    logic rst; logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd; logic hold;
    logic ar; logic br; logic we; logic [4:0] ea; logic [31:0] ed; logic [1:0] eg;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic drive(input vec_t v);
    rst_i = v.rst; wr_hold_i = v.hold;
    a_valid_i = v.av; a_addr_i = v.aa; a_data_i = v.ad;
    b_valid_i = v.bv; b_addr_i = v.ba; b_data_i = v.bd;
  endtask

  initial begin
    vec_t v;
    logic a_keep, b_keep;
    // rst av aa ad bv ba bd hold | ar br we addr data grant (sampled before the edge)
    tbl[0]  = '{1,0,0,0,         0,0,0,0,       0,0,0, 0,0,2'b00};
    tbl[1]  = '{1,1,5,32'h1234,  0,0,0,0,       1,0,0, 0,0,2'b00};
    tbl[2]  = '{1,0,0,0,         0,0,0,0,       0,0,1, 5,32'h1234,2'b01};
    tbl[3]  = '{0,0,0,0,         0,0,0,0,       0,0,0, 5,32'h1234,2'b00};
    tbl[4]  = '{1,1,3,7,         1,9,99,0,      1,0,0, 0,0,2'b00};
    tbl[5]  = '{1,1,3,7,         1,9,99,0,      0,1,1, 3,7,2'b01};
    tbl[6]  = '{1,1,3,7,         1,9,99,0,      1,0,1, 9,99,2'b10};
    tbl[7]  = '{1,1,3,7,         1,9,99,0,      0,1,1, 3,7,2'b01};
    tbl[8]  = '{1,0,0,0,         0,0,0,0,       0,0,1, 9,99,2'b10};
    tbl[9]  = '{1,0,0,0,         1,0,32'hFFFF,0,0,1,0, 9,99,2'b00};
    tbl[10] = '{1,0,0,0,         0,0,0,0,       0,0,0, 0,32'hFFFF,2'b10};
    tbl[11] = '{1,1,8,5,         0,0,0,0,       1,0,0, 0,32'hFFFF,2'b00};
    tbl[12] = '{1,0,0,0,         1,20,32'hAB,1, 0,0,0, 8,5,2'b01};
    tbl[13] = '{1,0,0,0,         1,20,32'hAB,1, 0,0,0, 8,5,2'b01};
    tbl[14] = '{1,0,0,0,         1,20,32'hAB,1, 0,0,0, 8,5,2'b01};
    tbl[15] = '{1,0,0,0,         1,20,32'hAB,0, 0,1,1, 8,5,2'b01};
    tbl[16] = '{1,0,0,0,         0,0,0,0,       0,0,1, 20,32'hAB,2'b10};
    tbl[17] = '{1,1,4,32'h44,    0,0,0,0,       1,0,0, 20,32'hAB,2'b00};
    tbl[18] = '{0,1,4,32'h44,    0,0,0,1,       0,0,0, 4,32'h44,2'b01};
    tbl[19] = '{1,1,6,6,         1,7,7,0,       1,0,0, 0,0,2'b00};
    tbl[20] = '{1,0,0,0,         0,0,0,0,       0,0,1, 6,6,2'b01};

`ifdef WB_FWD_EN
    RSaddr_i = '0; RTaddr_i = '0;
`endif
    v = '{0,0,0,0,0,0,0,0,0,0,0,0,0,2'b00};
    drive(v);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d a_ready", i), 32'(a_ready_o),  32'(tbl[i].ar));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready_o),  32'(tbl[i].br));
      chk($sformatf("v%0d RegWrite", i), 32'(RegWrite_o), 32'(tbl[i].we));
      chk($sformatf("v%0d RDaddr", i),  32'(RDaddr_o),   32'(tbl[i].ea));
      chk($sformatf("v%0d RDdata", i),  RDdata_o,        tbl[i].ed);
      chk($sformatf("v%0d grant", i),   32'(grant_o),    32'(tbl[i].eg));
      model_clock();
      @(posedge clk);
      #1;
    end

`ifdef WB_FWD_EN
    // Bypass match: stage holding r12, then a stage holding r0
    v = '{1,1,12,32'hC,0,0,0,0,0,0,0,0,0,2'b00};
    drive(v);
    @(posedge clk); #1;
    model_clock();
    v.hold = 1'b1; v.av = 1'b0;
    drive(v);
    RSaddr_i = 5'd12; RTaddr_i = 5'd0;
    #1;
    chk("fwd rs r12", 32'(RSfwd_o), 32'd1);
    chk("fwd rt r0",  32'(RTfwd_o), 32'd0);
    v.hold = 1'b0; v.av = 1'b1; v.aa = 5'd0;
    drive(v);
    @(negedge clk);
    model_clock();
    @(posedge clk); #1;
    v.av = 1'b0; v.hold = 1'b1;
    drive(v);
    RSaddr_i = 5'd0;
    #1;
    chk("fwd rs r0", 32'(RSfwd_o), 32'd0);
    @(negedge clk);
    model_clock();
    @(posedge clk); #1;
`endif

    // Random traffic; requesters keep their request until the model accepts it
    a_keep = 1'b0; b_keep = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst_i     = ($urandom_range(0, 49) != 0);
      wr_hold_i = ($urandom_range(0, 3) == 0);
      if (!a_keep) begin
        a_valid_i = ($urandom_range(0, 2) != 0);
        a_addr_i  = ADDR_W'($urandom_range(0, 31));
        a_data_i  = $urandom;
      end
      if (!b_keep) begin
        b_valid_i = ($urandom_range(0, 2) != 0);
        b_addr_i  = ADDR_W'($urandom_range(0, 31));
        b_data_i  = $urandom;
      end
`ifdef WB_FWD_EN
      RSaddr_i = ($urandom_range(0, 1) != 0) ? m_addr : ADDR_W'($urandom_range(0, 31));
      RTaddr_i = ADDR_W'($urandom_range(0, 31));
`endif
      @(negedge clk);
      chk("rnd a_ready",  32'(a_ready_o),  32'(stage_free() && win_a()));
      chk("rnd b_ready",  32'(b_ready_o),  32'(stage_free() && win_b()));
      chk("rnd RegWrite", 32'(RegWrite_o), 32'(m_full && !wr_hold_i && (m_addr != 0)));
      chk("rnd RDaddr",   32'(RDaddr_o),   32'(m_addr));
      chk("rnd RDdata",   RDdata_o,        m_data);
      chk("rnd grant",    32'(grant_o),    32'(m_src));
`ifdef WB_FWD_EN
      chk("rnd RSfwd", 32'(RSfwd_o), 32'(m_full && m_addr != 0 && m_addr == RSaddr_i));
      chk("rnd RTfwd", 32'(RTfwd_o), 32'(m_full && m_addr != 0 && m_addr == RTaddr_i));
`endif
      a_keep = a_valid_i && !(stage_free() && win_a());
      b_keep = b_valid_i && !(stage_free() && win_b());
      model_clock();
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
